// File: rtl/crossbar_req_demux.sv
// Single-master request demux onto four crossbar targets with a registered return-path select.
// Optional WAIT-state abort counter is enabled by defining CROSSBAR_TIMEOUT_EN.
module crossbar_req_demux #(
    parameter int unsigned TIMEOUT = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        m_busy,
    output logic        m_done,
    output logic        m_err,
    output logic [3:0]  s_req,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [3:0]  s_ack,
    output logic [2:0]  Answer
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  s_req_nxt;
    logic        s_we_nxt;
    logic [31:0] s_addr_nxt;
    logic [31:0] s_wdata_nxt;
    logic [2:0]  answer_nxt;
    logic        m_busy_nxt;
    logic        m_done_nxt;
    logic        m_err_nxt;

    logic [1:0]  sel_c;
    logic        ack_sel_c;
    logic        expired_c;

    // The latched address is the only record of the selected target.
    assign sel_c     = s_addr[31:30];
    assign ack_sel_c = s_ack[sel_c];

`ifdef CROSSBAR_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_cnt_nxt;

    assign expired_c = (tmo_cnt == CNT_W'(TIMEOUT));
`else
    logic [CNT_W-1:0] unused_timeout;

    assign unused_timeout = CNT_W'(TIMEOUT);
    assign expired_c      = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            s_req   <= 4'b0000;
            s_we    <= 1'b0;
            s_addr  <= 32'h0000_0000;
            s_wdata <= 32'h0000_0000;
            Answer  <= 3'b000;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_err   <= 1'b0;
`ifdef CROSSBAR_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            state   <= state_nxt;
            s_req   <= s_req_nxt;
            s_we    <= s_we_nxt;
            s_addr  <= s_addr_nxt;
            s_wdata <= s_wdata_nxt;
            Answer  <= answer_nxt;
            m_busy  <= m_busy_nxt;
            m_done  <= m_done_nxt;
            m_err   <= m_err_nxt;
`ifdef CROSSBAR_TIMEOUT_EN
            tmo_cnt <= tmo_cnt_nxt;
`endif
        end
    end

    // Next-state logic; an ack always beats an expiry in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m_req) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (ack_sel_c || expired_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        s_req_nxt   = s_req;
        s_we_nxt    = s_we;
        s_addr_nxt  = s_addr;
        s_wdata_nxt = s_wdata;
        answer_nxt  = Answer;
        m_done_nxt  = 1'b0;
        m_err_nxt   = 1'b0;
        m_busy_nxt  = (state_nxt != IDLE);
`ifdef CROSSBAR_TIMEOUT_EN
        tmo_cnt_nxt = tmo_cnt;
`endif
        case (state)
            IDLE: begin
                if (m_req) begin
                    s_we_nxt    = m_we;
                    s_addr_nxt  = m_addr;
                    s_wdata_nxt = m_wdata;
                    s_req_nxt   = 4'b0001 << m_addr[31:30];
                    answer_nxt  = {1'b1, m_addr[31:30]};
`ifdef CROSSBAR_TIMEOUT_EN
                    tmo_cnt_nxt = '0;
`endif
                end else begin
                    s_req_nxt  = 4'b0000;
                    answer_nxt = 3'b000;
                end
            end
            WAIT: begin
                if (ack_sel_c) begin
                    s_req_nxt  = 4'b0000;
                    m_done_nxt = 1'b1;
                end else if (expired_c) begin
                    s_req_nxt  = 4'b0000;
                    m_done_nxt = 1'b1;
                    m_err_nxt  = 1'b1;
                end else begin
`ifdef CROSSBAR_TIMEOUT_EN
                    tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
`endif
                end
            end
            DONE: begin
                s_req_nxt  = 4'b0000;
                answer_nxt = 3'b000;
            end
            default: begin
                s_req_nxt  = 4'b0000;
                answer_nxt = 3'b000;
            end
        endcase
    end

endmodule

// File: tb/tb_crossbar_req_demux.sv
// Directed bench for crossbar_req_demux; timeout cases run only with CROSSBAR_TIMEOUT_EN.
module tb_crossbar_req_demux;

`ifdef CROSSBAR_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 200;
`endif

    logic        clk;
    logic        reset;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_busy;
    logic        m_done;
    logic        m_err;
    logic [3:0]  s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_ack;
    logic [2:0]  Answer;

    int checks;
    int failures;

    crossbar_req_demux #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk     (clk),
        .reset   (reset),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_busy  (m_busy),
        .m_done  (m_done),
        .m_err   (m_err),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_ack   (s_ack),
        .Answer  (Answer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".s_req"},  64'(s_req),  64'h0);
        check({tag, ".answer"}, 64'(Answer), 64'h0);
        check({tag, ".busy"},   64'(m_busy), 64'h0);
        check({tag, ".done"},   64'(m_done), 64'h0);
        check({tag, ".err"},    64'(m_err),  64'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        m_req    = 1'b1;
        m_we     = 1'b1;
        m_addr   = 32'hC000_0000;
        m_wdata  = 32'h5555_AAAA;
        s_ack    = 4'b1111;

        // Reset held three cycles with a pending request
        repeat (3) cyc();
        check_idle("rst");
        check("rst.s_we",    64'(s_we),    64'h0);
        check("rst.s_addr",  64'(s_addr),  64'h0);
        check("rst.s_wdata", 64'(s_wdata), 64'h0);
        reset = 1'b1;
        m_req = 1'b0;
        s_ack = 4'b0000;
        cyc();
        check_idle("idle0");

        // Write to target 2, ack three cycles in, m_req in WAIT ignored
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'h8000_0010; m_wdata = 32'hDEAD_BEEF;
        cyc();
        check("t2.c1.s_req",  64'(s_req),   64'h4);
        check("t2.c1.answer", 64'(Answer),  64'h6);
        check("t2.c1.s_we",   64'(s_we),    64'h1);
        check("t2.c1.s_addr", 64'(s_addr),  64'h8000_0010);
        check("t2.c1.wdata",  64'(s_wdata), 64'hDEAD_BEEF);
        check("t2.c1.busy",   64'(m_busy),  64'h1);
        check("t2.c1.done",   64'(m_done),  64'h0);
        m_addr = 32'hC000_0000; m_we = 1'b0; m_wdata = 32'h0;
        cyc();
        check("t2.c2.s_req",  64'(s_req),  64'h4);
        check("t2.c2.s_addr", 64'(s_addr), 64'h8000_0010);
        check("t2.c2.s_we",   64'(s_we),   64'h1);
        check("t2.c2.answer", 64'(Answer), 64'h6);
        m_req = 1'b0;
        cyc();
        check("t2.c3.done", 64'(m_done), 64'h0);
        s_ack = 4'b0100;
        cyc();
        check("t2.c4.done",   64'(m_done), 64'h1);
        check("t2.c4.err",    64'(m_err),  64'h0);
        check("t2.c4.s_req",  64'(s_req),  64'h0);
        check("t2.c4.answer", 64'(Answer), 64'h6);
        check("t2.c4.busy",   64'(m_busy), 64'h1);
        s_ack = 4'b0000;
        cyc();
        check_idle("t2.c5");

        // Target 3 with ack already high: minimum latency, then back-to-back target 0
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'hC000_0004; m_wdata = 32'h1234;
        s_ack = 4'b1000;
        cyc();
        check("t3.c1.s_req",  64'(s_req),  64'h8);
        check("t3.c1.answer", 64'(Answer), 64'h7);
        check("t3.c1.s_we",   64'(s_we),   64'h0);
        m_req = 1'b0;
        cyc();
        check("t3.c2.done",   64'(m_done), 64'h1);
        check("t3.c2.answer", 64'(Answer), 64'h7);
        m_req = 1'b1; m_addr = 32'h0000_0000; s_ack = 4'b0000;
        cyc();
        check_idle("t3.c3");
        cyc();
        check("t0.c1.s_req",  64'(s_req),  64'h1);
        check("t0.c1.answer", 64'(Answer), 64'h4);
        m_req = 1'b0; s_ack = 4'b0001;
        cyc();
        check("t0.c2.done", 64'(m_done), 64'h1);
        s_ack = 4'b0000;
        cyc();
        check_idle("t0.c3");

        // Target 1: acks from other targets never complete the transaction
        m_req = 1'b1; m_addr = 32'h4000_0100;
        cyc();
        check("t1.s_req", 64'(s_req), 64'h2);
        m_req = 1'b0;
        s_ack = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check($sformatf("t1.noack%0d.done", i), 64'(m_done), 64'h0);
            check($sformatf("t1.noack%0d.s_req", i), 64'(s_req), 64'h2);
        end
        s_ack = 4'b0010;
        cyc();
        check("t1.done", 64'(m_done), 64'h1);
        check("t1.err",  64'(m_err),  64'h0);
        s_ack = 4'b0000;
        cyc();
        check_idle("t1.end");

        // Reset during WAIT on target 3 aborts silently
        m_req = 1'b1; m_addr = 32'hC000_0000;
        cyc();
        m_req = 1'b0;
        cyc();
        check("rw.s_req", 64'(s_req), 64'h8);
        reset = 1'b0;
        cyc();
        check_idle("rw.abort");
        reset = 1'b1;
        s_ack = 4'b1000;
        cyc();
        check_idle("rw.after");
        m_req = 1'b1; m_addr = 32'hC000_0040;
        cyc();
        check("rw.new.s_req", 64'(s_req), 64'h8);
        m_req = 1'b0;
        cyc();
        check("rw.new.done", 64'(m_done), 64'h1);
        check("rw.new.err",  64'(m_err),  64'h0);
        s_ack = 4'b0000;
        cyc();
        check_idle("rw.end");

`ifdef CROSSBAR_TIMEOUT_EN
        // No ack: expiry completes with error in cycle 10
        m_req = 1'b1; m_addr = 32'h4000_0000;
        cyc();
        m_req = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            check($sformatf("tmo.c%0d.done", i), 64'(m_done), 64'h0);
            cyc();
        end
        check("tmo.c10.done",  64'(m_done), 64'h1);
        check("tmo.c10.err",   64'(m_err),  64'h1);
        check("tmo.c10.s_req", 64'(s_req),  64'h0);
        cyc();
        check_idle("tmo.end");

        // Ack on the expiry cycle wins
        m_req = 1'b1; m_addr = 32'h4000_0000;
        cyc();
        m_req = 1'b0;
        repeat (8) cyc();
        s_ack = 4'b0010;
        cyc();
        check("tmoack.done", 64'(m_done), 64'h1);
        check("tmoack.err",  64'(m_err),  64'h0);
        s_ack = 4'b0000;
        cyc();
        check_idle("tmoack.end");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
